// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result handshake bundle for serial_adder_ctrl
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout, busy);
  modport slave (input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sharing one full-adder cell over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to honour the sub port (a - b); otherwise every operation is a + b + cin.
module serial_adder_ctrl #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry_q, fa_b, fa_s, fa_c;
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  assign fa_b = b_sh[0] ^ sub_q;
`else
  logic unused_sub;
  assign unused_sub = s.sub;
  assign fa_b = b_sh[0];
`endif
  assign fa_s = a_sh[0] ^ fa_b ^ carry_q;
  assign fa_c = (a_sh[0] & fa_b) | (carry_q & (a_sh[0] ^ fa_b));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (s.in_valid) begin
          a_sh  <= s.a;
          b_sh  <= s.b;
          cnt   <= '0;
          state <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
          sub_q   <= s.sub;
          carry_q <= s.sub | s.cin;
`else
          carry_q <= s.cin;
`endif
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= {fa_s, sum_sh[WIDTH-1:1]};
          carry_q <= fa_c;
          cnt     <= cnt + CW'(1);
          state   <= (cnt == CW'(WIDTH - 1)) ? DONE : RUN;
        end
        DONE: state <= s.out_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign s.in_ready  = state == IDLE;
  assign s.out_valid = state == DONE;
  assign s.busy      = state != IDLE;
  assign s.sum       = sum_sh;
  assign s.cout      = carry_q;
endmodule
